// File: rtl/v60_mem_responder.sv
// Memory-side responder for the v60_cpu bus: byte-addressed RAM with
// little-endian byte/halfword/word access, wait states and a backdoor loader.
module v60_mem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_req,
    input  logic                  mem_wr,
    input  logic [1:0]            mem_size,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_ready,
    output logic                  mem_err,
    output logic                  busy,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [7:0]            load_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam bit NO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] CNT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic                  wr_q;
    logic [1:0]            size_q;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  acc_wr;
    logic [1:0]            acc_size;
    logic [DEPTH_LOG2-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;

    logic [3:0]            lane_en;
    logic [DEPTH_LOG2-1:0] idx [4];
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  commit;
    logic                  acc_rsvd;

    logic [7:0] mem [DEPTH];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[ADDR_WIDTH-1:DEPTH_LOG2],
                                load_addr[ADDR_WIDTH-1:DEPTH_LOG2]};

    // Zero-wait commits happen at the acceptance edge, so use live inputs
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_wr    = mem_wr;
            acc_size  = mem_size;
            acc_addr  = mem_addr[DEPTH_LOG2-1:0];
            acc_wdata = mem_wdata;
        end else begin
            acc_wr    = wr_q;
            acc_size  = size_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    always_comb begin
        lane_en = 4'b0000;
        unique case (1'b1)
            acc_size == 2'b00: lane_en = 4'b0001;
            acc_size == 2'b01: lane_en = 4'b0011;
            acc_size == 2'b10: lane_en = 4'b1111;
            default:           lane_en = 4'b0000;
        endcase
    end

    assign acc_rsvd = (acc_size == 2'b11);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            idx[i] = acc_addr + DEPTH_LOG2'(i);
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
                rd_word[8*i +: 8] = mem[idx[i]];
            end
        end
    end

    // Gated by rst_n so a request held during reset never writes the RAM
    assign commit = rst_n &&
                    (((state_q == S_IDLE) && mem_req && NO_WAIT) ||
                     ((state_q == S_WAIT) && (cnt_q == 4'd0)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    if (NO_WAIT) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if ((state_q == S_IDLE) && mem_req) begin
            wr_q    <= mem_wr;
            size_q  <= mem_size;
            addr_q  <= mem_addr[DEPTH_LOG2-1:0];
            wdata_q <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            err_q <= commit && acc_rsvd;
            if (commit && acc_rsvd) begin
                rdata_q <= 32'hDEAD_BEEF;
            end else if (commit && !acc_wr) begin
                rdata_q <= rd_word;
            end
        end
    end

    // Bus lanes are assigned last so they win a same-byte backdoor collision
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr[DEPTH_LOG2-1:0]] <= load_data;
        end
        if (commit && acc_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[idx[i]] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign mem_ready = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign mem_err   = err_q;
    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_v60_mem_responder.sv
// Bench for v60_mem_responder: three instances (0, 3 and 2 wait states),
// random bus traffic scored against a byte-array reference memory.
module tb_v60_mem_responder;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n_a    [3];
    logic        req_a      [3];
    logic        wr_a       [3];
    logic [1:0]  size_a     [3];
    logic [31:0] addr_a     [3];
    logic [31:0] wdata_a    [3];
    logic [31:0] rdata_a    [3];
    logic        ready_a    [3];
    logic        err_a      [3];
    logic        busy_a     [3];
    logic        load_en_a  [3];
    logic [31:0] load_addr_a[3];
    logic [7:0]  load_data_a[3];

    logic [7:0]  mdl     [3][1024];
    logic [31:0] last_rd [3];
    int          busy_run[3];
    exp_t        sb[$];

    int n_chk  = 0;
    int n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 0 : ((g == 1) ? 3 : 2);

        v60_mem_responder #(.WAIT_STATES(W)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n_a[g]),
            .mem_req   (req_a[g]),
            .mem_wr    (wr_a[g]),
            .mem_size  (size_a[g]),
            .mem_addr  (addr_a[g]),
            .mem_wdata (wdata_a[g]),
            .mem_rdata (rdata_a[g]),
            .mem_ready (ready_a[g]),
            .mem_err   (err_a[g]),
            .busy      (busy_a[g]),
            .load_en   (load_en_a[g]),
            .load_addr (load_addr_a[g]),
            .load_data (load_data_a[g])
        );

        always @(negedge clk) begin
            exp_t e;
            if (!rst_n_a[g]) begin
                busy_run[g] = 0;
            end else begin
                if (busy_a[g]) busy_run[g] = busy_run[g] + 1;
                if (ready_a[g]) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        $display("FAIL spurious_ready%0d: got ready, expected none", g);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("resp_id%0d", g), g, e.id);
                        chk($sformatf("rdata%0d", g), rdata_a[g], e.rdata);
                        chk($sformatf("err%0d", g), {31'd0, err_a[g]}, {31'd0, e.err});
                        chk($sformatf("busy_len%0d", g), busy_run[g], W + 1);
                    end
                    busy_run[g] = 0;
                end else begin
                    if (!busy_a[g]) busy_run[g] = 0;
                    if (err_a[g]) begin
                        n_chk++;
                        $display("FAIL err_no_ready%0d: got err=1, expected 0", g);
                    end
                end
            end
        end
    end

    // Reference: apply the access to the byte array, push the expected response
    task automatic model_op(input int k, input logic w, input logic [1:0] s,
                            input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        int          n;
        logic [31:0] r;
        n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 0;
        e.id  = k;
        e.err = (s == 2'd3);
        if (s == 2'd3) begin
            last_rd[k] = 32'hDEAD_BEEF;
        end else if (w) begin
            for (int i = 0; i < n; i++)
                mdl[k][(a + 32'(i)) % 1024] = d[8*i +: 8];
        end else begin
            r = '0;
            for (int i = 0; i < n; i++)
                r[8*i +: 8] = mdl[k][(a + 32'(i)) % 1024];
            last_rd[k] = r;
        end
        e.rdata = last_rd[k];
        sb.push_back(e);
    endtask

    task automatic load(input int k, input logic [31:0] a, input logic [7:0] d);
        load_en_a[k]   = 1'b1;
        load_addr_a[k] = a;
        load_data_a[k] = d;
        mdl[k][a % 1024] = d;
        @(negedge clk);
        load_en_a[k] = 1'b0;
    endtask

    task automatic xact(input int k, input logic w, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit chained, input bit hold);
        int n;
        n = 0;
        req_a[k]   = 1'b1;
        wr_a[k]    = w;
        size_a[k]  = s;
        addr_a[k]  = a;
        wdata_a[k] = d;
        model_op(k, w, s, a, d);
        do begin
            @(negedge clk);
            n++;
            load_en_a[k] = 1'b0;
            if (!ready_a[k] && n > int'(chained)) begin
                addr_a[k]  = $urandom;
                wdata_a[k] = $urandom;
                wr_a[k]    = 1'($urandom_range(0, 1));
                size_a[k]  = 2'($urandom_range(0, 3));
            end
        end while (!ready_a[k] && n < 40);
        chk($sformatf("latency%0d", k), n, ws_of(k) + 1 + int'(chained));
        if (!hold) begin
            req_a[k] = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n_a[k] = 1'b0;  req_a[k] = 1'b0;  wr_a[k] = 1'b0;
            size_a[k] = 2'b00;  addr_a[k] = '0;   wdata_a[k] = '0;
            load_en_a[k] = 1'b0; load_addr_a[k] = '0; load_data_a[k] = '0;
            last_rd[k] = '0;    busy_run[k] = 0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ready%0d", k), {31'd0, ready_a[k]}, 32'd0);
            chk($sformatf("rst_err%0d", k), {31'd0, err_a[k]}, 32'd0);
            chk($sformatf("rst_busy%0d", k), {31'd0, busy_a[k]}, 32'd0);
            chk($sformatf("rst_rdata%0d", k), rdata_a[k], 32'd0);
        end

        // Preload while held in reset: clear RAM, then the boot pattern
        for (int a = 0; a < 1024; a++) begin
            for (int k = 0; k < 3; k++) begin
                load_en_a[k] = 1'b1;  load_addr_a[k] = a;
                load_data_a[k] = 8'h00; mdl[k][a] = 8'h00;
            end
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) load_en_a[k] = 1'b0;
        load(0, 0, 8'h78); load(0, 1, 8'h56);
        load(0, 2, 8'h34); load(0, 3, 8'h12);
        for (int k = 0; k < 3; k++) rst_n_a[k] = 1'b1;
        @(negedge clk);

        xact(0, 0, 2'b10, 32'h0, 32'h0, 0, 0);
        xact(0, 1, 2'b01, 32'h5, 32'hAAAA_BEEF, 0, 0);
        xact(0, 0, 2'b10, 32'h4, 32'h0, 0, 0);
        xact(0, 1, 2'b10, 32'h3FE, 32'h1122_3344, 0, 0);
        xact(0, 0, 2'b00, 32'h400, 32'h0, 0, 0);
        xact(0, 0, 2'b10, 32'h3FE, 32'h0, 0, 0);
        xact(0, 1, 2'b11, 32'h0, 32'hFFFF_FFFF, 0, 0);
        xact(0, 0, 2'b11, 32'h10, 32'h0, 0, 1);
        xact(0, 0, 2'b10, 32'h0, 32'h0, 1, 0);

        load(1, 32'h40, 8'hC3); load(1, 32'h41, 8'h3C);
        xact(1, 0, 2'b10, 32'h40, 32'h0, 0, 0);
        xact(1, 1, 2'b10, 32'h7FF, 32'h5566_7788, 0, 0);
        xact(1, 0, 2'b10, 32'h3FF, 32'h0, 0, 0);

        // Backdoor and bus write hit byte 0x21 on the same edge
        load_en_a[0] = 1'b1; load_addr_a[0] = 32'h21; load_data_a[0] = 8'h5A;
        mdl[0][32'h21] = 8'h5A;
        xact(0, 1, 2'b10, 32'h20, 32'h0102_0304, 0, 0);
        xact(0, 0, 2'b10, 32'h20, 32'h0, 0, 0);

        // Reset during WAIT discards the pending write
        load(2, 8, 8'hA1); load(2, 9, 8'hA2);
        load(2, 10, 8'hA3); load(2, 11, 8'hA4);
        xact(2, 0, 2'b10, 32'h8, 32'h0, 0, 0);
        req_a[2] = 1'b1; wr_a[2] = 1'b1; size_a[2] = 2'b10;
        addr_a[2] = 32'h8; wdata_a[2] = 32'hCAFE_F00D;
        @(negedge clk);
        rst_n_a[2] = 1'b0;
        #1;
        chk("abort_ready", {31'd0, ready_a[2]}, 32'd0);
        chk("abort_busy", {31'd0, busy_a[2]}, 32'd0);
        chk("abort_err", {31'd0, err_a[2]}, 32'd0);
        chk("abort_rdata", rdata_a[2], 32'd0);
        req_a[2] = 1'b0;
        last_rd[2] = '0;
        repeat (2) @(negedge clk);
        rst_n_a[2] = 1'b1;
        @(negedge clk);
        xact(2, 0, 2'b10, 32'h8, 32'h0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            int k;
            k = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0)
                load(k, $urandom, 8'($urandom));
            else
                xact(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     (i % 2 == 0) ? $urandom : 32'($urandom_range(1016, 1031)),
                     $urandom, 0, 0);
        end

        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
